// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into SLICE-bit ripple stages, one register per stage, valid/ready flow.
// Define PIPELINED_ADDER_SAT_EN to saturate sum to the signed bound on overflow.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SLICE;
    localparam int L = STAGES - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of SLICE");
    end

    logic             advance;
    logic [WIDTH-1:0] ia [STAGES];
    logic [WIDTH-1:0] ib [STAGES];
    logic [WIDTH-1:0] ir [STAGES];
    logic [WIDTH-1:0] nr [STAGES];
    logic [WIDTH-1:0] qa [STAGES];
    logic [WIDTH-1:0] qb [STAGES];
    logic [WIDTH-1:0] qr [STAGES];
    logic [SLICE-1:0] s  [STAGES];
    logic             ic [STAGES];
    logic             iv [STAGES];
    logic             co [STAGES];
    logic             qc [STAGES];
    logic             qv [STAGES];
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operands shift right one slice per stage; results shift in from the top, so the last stage is aligned.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign ia[k] = a;
            assign ib[k] = sub ? ~b : b;
            assign ic[k] = cin ^ sub;
            assign iv[k] = in_valid;
            assign ir[k] = '0;
        end else begin : g_tail
            assign ia[k] = qa[k-1];
            assign ib[k] = qb[k-1];
            assign ic[k] = qc[k-1];
            assign iv[k] = qv[k-1];
            assign ir[k] = qr[k-1];
        end
        assign {co[k], s[k]} = {1'b0, ia[k][SLICE-1:0]} + {1'b0, ib[k][SLICE-1:0]} + {{SLICE{1'b0}}, ic[k]};
        assign nr[k] = (WIDTH'(s[k]) << (WIDTH - SLICE)) | (ir[k] >> SLICE);
    end

    // The top slice is summed last: its operand MSBs and sum MSB recover the carry into the MSB.
    assign ovf = ia[L][SLICE-1] ^ ib[L][SLICE-1] ^ s[L][SLICE-1] ^ co[L];
`ifdef PIPELINED_ADDER_SAT_EN
    assign res = ovf ? {ia[L][SLICE-1], {(WIDTH-1){~ia[L][SLICE-1]}}} : nr[L];
`else
    assign res = nr[L];
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                qv[i] <= 1'b0;
                qc[i] <= 1'b0;
                qa[i] <= '0;
                qb[i] <= '0;
                qr[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (advance) begin
            for (int i = 0; i < STAGES; i++) begin
                qv[i] <= iv[i];
                if (iv[i]) begin
                    qc[i] <= co[i];
                    qa[i] <= ia[i] >> SLICE;
                    qb[i] <= ib[i] >> SLICE;
                    qr[i] <= (i == L) ? res : nr[i];
                end
            end
            if (iv[L]) overflow <= ovf;
        end
    end

    assign sum       = qr[L];
    assign cout      = qc[L];
    assign out_valid = qv[L];
endmodule
